cond_logic: RTL and testbench

Conditional-execution stage that sits directly downstream of the instruction decoder and ALU in the ARM datapath. It holds the architectural NZCV flags register and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's PCS/RegW/MemW into the final PCSrc/RegWrite/MemWrite strobes. It also keeps a saturating count of condition-failed (skipped) instructions for debug.

---
 rtl/cond_logic.sv | 82 ++++++++
 tb/tb_cond_logic.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the condition
// field against them, gates the decoder write strobes and counts skipped instructions.
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             Stall,
   input  logic             ClrCount,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic             Undef,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SkipCount
);

   logic n, z, c, v;
   logic write_ok;

   assign {n, z, c, v} = Flags;

   // Condition is judged only against the stored flags, never the ALU's new ones.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = (n == v);
         4'b1011: CondEx = (n != v);
         4'b1100: CondEx = ~z & (n == v);
         4'b1101: CondEx = z | (n != v);
         4'b1110: CondEx = 1'b1;
         4'b1111: CondEx = 1'b0;
      endcase
   end

   assign Undef    = (Cond == 4'b1111);
   assign write_ok = CondEx & ~Stall;
   assign PCSrc    = PCS  & write_ok;
   assign RegWrite = RegW & write_ok;
   assign MemWrite = MemW & write_ok;

   // FlagW is only looked at once write_ok is known true, so an undriven
   // FlagW during a stall or failed condition cannot reach the register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         Flags <= 4'b0000;
      end else if (write_ok) begin
         if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         SkipCount <= '0;
      end else if (ClrCount) begin
         SkipCount <= '0;
      end else if (!Stall && !CondEx && (SkipCount != '1)) begin
         SkipCount <= SkipCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios with literal expectations
// followed by randomized traffic compared each cycle against a behavioural model.
module tb_cond_logic;

   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       Cond, ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, RegW, MemW, Stall, ClrCount;
   logic             PCSrc, RegWrite, MemWrite, CondEx, Undef;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] SkipCount;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model state: architectural flags and skip counter.
   logic [3:0] m_flags = 4'b0000;
   int         m_cnt   = 0;

   cond_logic #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .Stall(Stall), .ClrCount(ClrCount),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Undef(Undef), .Flags(Flags), .SkipCount(SkipCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ARM condition codes come in pairs: odd code is the negation of the even one.
   function automatic logic m_pass(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cc[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cc == 4'hF) return 1'b0;
      return cc[0] ? !base : base;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         logic pass, go;
         pass = m_pass(Cond, m_flags);
         go   = pass && !Stall;
         check("CondEx",    32'(CondEx),    32'(pass));
         check("Undef",     32'(Undef),     32'(Cond == 4'hF));
         check("PCSrc",     32'(PCSrc),     32'(PCS && go));
         check("RegWrite",  32'(RegWrite),  32'(RegW && go));
         check("MemWrite",  32'(MemWrite),  32'(MemW && go));
         check("Flags",     32'(Flags),     32'(m_flags));
         check("SkipCount", 32'(SkipCount), 32'(m_cnt));
      end
   end

   task automatic drive(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                        input logic pcs, input logic rw, input logic mw,
                        input logic st, input logic clr);
      Cond = cc; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
      Stall = st; ClrCount = clr;
   endtask

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic step();
      @(posedge clk);
      if (!reset) begin
         logic pass;
         pass = m_pass(Cond, m_flags);
         if (ClrCount)                       m_cnt = 0;
         else if (!Stall && !pass && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (!Stall && pass) begin
            if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
         end
      end
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      drive(4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("set_flags", 32'(Flags), 32'(f));
   endtask

   task automatic expect_cond(input logic [3:0] cc, input logic exp, input string name);
      Cond = cc;
      #1;
      check(name, 32'(CondEx), 32'(exp));
   endtask

   initial begin
      logic [3:0] f_save;
      logic [CNT_W-1:0] c_save;

      reset = 1'b1;
      drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cmp_en = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();

      // Reset mid-cycle with flags all ones clears immediately.
      set_flags(4'b1111);
      step();
      #2;
      reset = 1'b1;
      m_flags = 4'b0000;
      m_cnt   = 0;
      #1;
      check("async_reset_flags", 32'(Flags), 32'd0);
      check("async_reset_cnt",   32'(SkipCount), 32'd0);
      step();
      reset = 1'b0;
      expect_cond(4'h0, 1'b0, "post_reset_EQ");
      expect_cond(4'hE, 1'b1, "post_reset_AL");

      // Flag write then use in the following cycle.
      drive(4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("al_regwrite", 32'(RegWrite), 32'd1);
      step();
      check("flags_0100", 32'(Flags), 32'h4);
      drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_cond(4'h0, 1'b1, "EQ_after_write");
      expect_cond(4'h1, 1'b0, "NE_after_write");
      step();
      check("skip_incr", 32'(SkipCount), 32'd1);

      // Partial write: N,Z only.
      set_flags(4'b1010);
      drive(4'hE, 4'b0101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("partial_nz", 32'(Flags), 32'b0110);

      // Signed and unsigned compares.
      set_flags(4'b1001);
      expect_cond(4'hA, 1'b1, "GE_1001");
      expect_cond(4'hB, 1'b0, "LT_1001");
      expect_cond(4'hC, 1'b1, "GT_1001");
      expect_cond(4'hD, 1'b0, "LE_1001");
      set_flags(4'b1100);
      expect_cond(4'hC, 1'b0, "GT_1100");
      expect_cond(4'hD, 1'b1, "LE_1100");
      set_flags(4'b0010);
      expect_cond(4'h8, 1'b1, "HI_0010");
      set_flags(4'b0110);
      expect_cond(4'h8, 1'b0, "HI_0110");
      expect_cond(4'h9, 1'b1, "LS_0110");

      // Failed condition gates strobes and flags.
      set_flags(4'b0010);
      drive(4'h0, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      check("fail_strobes", 32'({PCSrc, RegWrite, MemWrite}), 32'd0);
      step();
      check("fail_flags_hold", 32'(Flags), 32'b0010);

      // Stall with AL suppresses everything.
      c_save = SkipCount;
      drive(4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("stall_strobes", 32'({PCSrc, RegWrite, MemWrite}), 32'd0);
      step();
      check("stall_flags_hold", 32'(Flags), 32'b0010);
      check("stall_cnt_hold", 32'(SkipCount), 32'(c_save));

      drive(4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("undef_flag", 32'(Undef), 32'd1);
      check("undef_condex", 32'(CondEx), 32'd0);

      // Saturation, stall hold, clear-over-stall.
      drive(4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("clr_cnt", 32'(SkipCount), 32'd0);
      ClrCount = 1'b0;
      repeat (10) step();
      check("saturate", 32'(SkipCount), 32'd7);
      Stall = 1'b1;
      step();
      check("sat_stall_hold", 32'(SkipCount), 32'd7);
      ClrCount = 1'b1;
      step();
      check("clr_over_stall", 32'(SkipCount), 32'd0);

      // Randomized traffic, compared every cycle by the negedge process.
      f_save = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) Cond = 4'hE;
         step();
         f_save = f_save | Flags;
      end
      check("random_flags_seen", 32'(f_save), 32'hF);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
